// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   - uart_state_e   : receiver FSM state encoding
//   - OVERSAMPLE_DEF : default number of sample ticks per bit
//   - 8N1 frame constants (data bits, line levels)
//   - calc_div()     : clock-to-tick divider value, truncated, never below 1
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_e;

    localparam int OVERSAMPLE_DEF = 16;

    // 8N1 framing
    localparam int   DATA_BITS  = 8;
    localparam int   STOP_BITS  = 1;
    localparam logic IDLE_LEVEL = 1'b1;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_LEVEL = 1'b1;

    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        int d;
        d = clk_freq / (baud * os);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: free-running divider producing one-cycle sample ticks.
// Ports:
//   clk_i     : system clock
//   rst_ni    : asynchronous active-low reset
//   restart_i : synchronous restart, counter returns to zero, no tick this cycle
//   tick_o    : one-cycle pulse every DIV clocks
module baud_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With DIV == 1 the counter stays at zero and ticks every cycle.
    assign tick_o = !restart_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 oversampling UART receiver.
// Ports:
//   clk_i       : system clock, rising edge
//   rst_ni      : asynchronous active-low reset
//   rx_i        : asynchronous serial line, idle high, LSB first
//   data_o      : last correctly framed byte, held between strobes
//   valid_o     : one-cycle strobe, data_o updated
//   frame_err_o : one-cycle strobe, stop bit sampled low
//   busy_o      : high whenever the FSM is not idle
//
// Handshake: valid_o and frame_err_o are registered single-cycle strobes,
// mutually exclusive, with no backpressure; a consumer must take data_o in
// the cycle valid_o is high (or any time before the next strobe).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 24000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

    // Synchronizer plus one history flop for edge detection; all idle high
    // so a line held low through reset release needs two cycles to be seen.
    logic rx_meta_q, rx_s_q, rx_prev_q;

    uart_state_e           state_q, state_d;
    logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [7:0]            data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;

    logic start_edge;
    logic tick;

    // Falling edge is only looked for in IDLE; WAIT_HIGH ignores the line
    // until it returns high, so a break yields a single frame error.
    assign start_edge = (state_q == ST_IDLE) && rx_prev_q && !rx_s_q;

    // Divider restarts on the start edge so the first tick lands DIV clocks
    // later and mid-bit sampling is phase-aligned to the falling edge.
    baud_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .restart_i(start_edge),
        .tick_o   (tick)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= IDLE_LEVEL;
            rx_s_q    <= IDLE_LEVEL;
            rx_prev_q <= IDLE_LEVEL;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                if (start_edge) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        // Line back high at mid-start: glitch, drop silently.
                        state_d = (rx_s_q == START_BIT) ? ST_DATA : ST_IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end

            ST_DATA: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end

            ST_STOP: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        // Leaving at mid-stop leaves half a bit to catch a
                        // back-to-back start edge from IDLE.
                        if (rx_s_q == STOP_LEVEL) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_WAIT_HIGH;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end

            ST_WAIT_HIGH: begin
                if (rx_s_q == IDLE_LEVEL) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at CLK_FREQ=1600000, BAUD=10000
// (DIV=10, 160 clocks per bit). A driver serialises frames onto rx_i and
// pushes the expected strobe into exp_q; a monitor pops on every strobe.
module tb_uart_rx;

    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 10000;
    localparam int OS       = 16;
    localparam int BIT      = 160;
    // Start edge to strobe: 2 sync + 1 detect + 152 ticks of 10 clocks.
    localparam int LAT_MIN  = 1515;
    localparam int LAT_MAX  = 1531;

    logic       clk;
    logic       rst_ni;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       busy_o;

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OS)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .rx_i       (rx_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .frame_err_o(frame_err_o),
        .busy_o     (busy_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    // exp_q entry: {is_frame_err, expected data_o}
    logic [8:0] exp_q[$];
    int         start_q[$];
    int         checks = 0;
    int         errors = 0;
    int         ferr_total = 0;
    int         last_valid_cyc = 0;
    int         prev_valid_cyc = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ferr = 1'b0;
    logic [7:0] last_good = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_ni) begin
            logic [8:0] e;
            int         s;
            int         lat;
            if (valid_o && frame_err_o) check("strobes_exclusive", 1, 0);
            if (valid_o && prev_valid) check("valid_one_cycle", 1, 0);
            if (frame_err_o && prev_ferr) check("ferr_one_cycle", 1, 0);
            if (frame_err_o) ferr_total++;
            if (valid_o || frame_err_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe valid=%0b ferr=%0b data=%0h required none", valid_o, frame_err_o, data_o);
                end else begin
                    e   = exp_q.pop_front();
                    s   = start_q.pop_front();
                    lat = cyc - s;
                    check("strobe_kind", frame_err_o, e[8]);
                    check("data", data_o, e[7:0]);
                    checks++;
                    if (lat < LAT_MIN || lat > LAT_MAX) begin
                        errors++;
                        $display("FAIL latency actual=%0d required=%0d..%0d", lat, LAT_MIN, LAT_MAX);
                    end
                end
            end
            if (valid_o) begin
                prev_valid_cyc = last_valid_cyc;
                last_valid_cyc = cyc;
            end
        end
        prev_valid = valid_o;
        prev_ferr  = frame_err_o;
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        exp_q.push_back({~stop_bit, (stop_bit ? b : last_good)});
        start_q.push_back(cyc);
        if (stop_bit) last_good = b;
        rx_i = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            idle(BIT);
        end
        rx_i = stop_bit;
        idle(BIT);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    logic [7:0] msg [16];
    int         gap_tbl [4];

    // ---------------- stimulus ----------------
    initial begin
        msg = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h2c, 8'h20, 8'h55,
                8'h41, 8'h52, 8'h54, 8'h20, 8'h72, 8'h78, 8'h21, 8'h00};
        gap_tbl = '{0, 3, 0, 37};
        rx_i   = 1'b1;
        rst_ni = 1'b0;
        idle(5);
        check("reset_data", data_o, 8'h00);
        check("reset_valid", valid_o, 0);
        check("reset_ferr", frame_err_o, 0);
        check("reset_busy", busy_o, 0);
        rst_ni = 1'b1;
        idle(20);

        // single frame
        send_frame(8'h55, 1'b1);
        drain("drain_55");
        check("busy_after_55", busy_o, 0);
        idle(100);

        // back-to-back, zero gap
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        drain("drain_a5_3c");
        check("b2b_spacing", last_valid_cyc - prev_valid_cyc, BIT * 10);
        check("data_hold_3c", data_o, 8'h3C);
        idle(100);

        // 40-clock low glitch
        rx_i = 1'b0;
        idle(20);
        check("glitch_busy_high", busy_o, 1);
        idle(20);
        rx_i = 1'b1;
        idle(80);
        check("glitch_busy_low", busy_o, 0);
        idle(100);

        // stop bit low, then line held low
        send_frame(8'h81, 1'b0);
        idle(3000 - BIT);
        check("break_busy_high", busy_o, 1);
        check("break_data_held", data_o, 8'h3C);
        rx_i = 1'b1;
        idle(6);
        check("break_busy_low", busy_o, 0);
        check("break_one_ferr", ferr_total, 1);
        idle(100);

        // reset during bit 4 of 0xFF
        rx_i = 1'b0;
        idle(BIT);
        rx_i = 1'b1;
        idle(BIT * 4 + 80);
        rst_ni = 1'b0;
        idle(2);
        check("midrst_data", data_o, 8'h00);
        check("midrst_valid", valid_o, 0);
        check("midrst_ferr", frame_err_o, 0);
        check("midrst_busy", busy_o, 0);
        rst_ni = 1'b1;
        last_good = 8'h00;
        idle(BIT * 5);
        check("postrst_busy", busy_o, 0);
        check("postrst_data", data_o, 8'h00);
        send_frame(8'h12, 1'b1);
        drain("drain_12");
        check("data_12", data_o, 8'h12);
        idle(50);

        // loopback string
        for (int i = 0; i < 16; i++) begin
            send_frame(msg[i], 1'b1);
            idle(gap_tbl[i % 4]);
        end
        drain("drain_string");
        check("string_last", data_o, 8'h00);
        check("total_ferr", ferr_total, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
